// File: rtl/jtframe_rom_pkg.sv
// Shared constants and types for the ROM read arbiter.
package jtframe_rom_pkg;

  localparam int unsigned ROMARB_FIXED = 0;
  localparam int unsigned ROMARB_RR    = 1;
  localparam int unsigned DEFAULT_AW   = 22;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } romarb_st_t;

endpackage

// File: rtl/jtframe_romarb_pick.sv
// Combinational pick: first active slot searched from last_grant+1, wrapping.
// Fixed priority is obtained by holding last_grant at SLOTS-1.
module jtframe_romarb_pick #(
  parameter int unsigned SLOTS = 9,
  parameter int unsigned IW    = 4
) (
  input  logic [SLOTS-1:0] active,
  input  logic [IW-1:0]    last_grant,
  output logic [SLOTS-1:0] pick_oh,
  output logic [IW-1:0]    pick_idx
);

  always_comb begin
    logic        found;
    int unsigned j;
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = 0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      j = 32'(last_grant) + k + 1;
      if (j >= SLOTS) j = j - SLOTS;
      if (!found && active[IW'(j)]) begin
        found              = 1'b1;
        pick_oh[IW'(j)]    = 1'b1;
        pick_idx           = IW'(j);
      end
    end
  end

endmodule

// File: rtl/jtframe_romarb.sv
// SDRAM read arbiter for SLOTS ROM clients, fixed-priority or round-robin.
// Optional watchdog abort enabled by defining JTFRAME_ROMARB_WDOG_EN.
module jtframe_romarb
  import jtframe_rom_pkg::*;
#(
  parameter int unsigned SLOTS = 9,
  parameter int unsigned AW    = DEFAULT_AW,
  parameter int unsigned RR    = ROMARB_FIXED,
  parameter int unsigned TOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic                vblank,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_sel,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [AW-1:0]       sdram_addr,
  input  logic                data_rdy,
  output logic                refresh_en,
  output logic                ready,
  output logic                timeout
);

  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  romarb_st_t       st;
  logic [SLOTS-1:0] active_c;
  logic [SLOTS-1:0] pick_oh_c;
  logic [IW-1:0]    pick_idx_c;
  logic [IW-1:0]    last_grant;
  logic [3:0]       rdy_sr;
  logic             grant_opp_c;
  logic [AW-1:0]    addr_arr [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_addr
    assign addr_arr[i] = slot_addr[i*AW +: AW];
  end

  // The slot currently being served never competes for the next grant
  assign active_c    = slot_req & ~slot_sel;
  assign grant_opp_c = (st == ST_IDLE) || data_rdy;
  assign ready       = rdy_sr[3];

  jtframe_romarb_pick #(
    .SLOTS (SLOTS),
    .IW    (IW)
  ) u_pick (
    .active     (active_c),
    .last_grant (last_grant),
    .pick_oh    (pick_oh_c),
    .pick_idx   (pick_idx_c)
  );

`ifdef JTFRAME_ROMARB_WDOG_EN
  localparam int unsigned WW = (TOUT > 1) ? $clog2(TOUT) : 1;
  logic [WW-1:0] wdog;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || downloading) begin
      st         <= ST_IDLE;
      slot_sel   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      refresh_en <= 1'b0;
      rdy_sr     <= '0;
      last_grant <= IW'(SLOTS - 1);
`ifdef JTFRAME_ROMARB_WDOG_EN
      timeout    <= 1'b0;
      wdog       <= '0;
`endif
    end else begin
      rdy_sr     <= {rdy_sr[2:0], 1'b1};
      refresh_en <= 1'b0;
      if (grant_opp_c) begin
        if (|active_c) begin
          st         <= ST_BUSY;
          slot_sel   <= pick_oh_c;
          sdram_addr <= addr_arr[pick_idx_c];
          sdram_req  <= 1'b1;
          if (RR == ROMARB_RR) last_grant <= pick_idx_c;
        end else begin
          st         <= ST_IDLE;
          slot_sel   <= '0;
          sdram_req  <= 1'b0;
          refresh_en <= vblank;
        end
      end else if (sdram_ack) begin
        sdram_req <= 1'b0;
      end
`ifdef JTFRAME_ROMARB_WDOG_EN
      // Abort on the TOUT-th consecutive BUSY cycle without data
      timeout <= 1'b0;
      if (grant_opp_c) begin
        wdog <= '0;
      end else if (wdog == WW'(TOUT - 1)) begin
        st        <= ST_IDLE;
        slot_sel  <= '0;
        sdram_req <= 1'b0;
        timeout   <= 1'b1;
        wdog      <= '0;
      end else begin
        wdog <= wdog + WW'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_jtframe_romarb.sv
// Directed bench: fixed-priority and round-robin instances on shared stimulus.
module tb_jtframe_romarb;

  localparam int unsigned SLOTS = 9;
  localparam int unsigned AW    = 22;

  logic                clk = 1'b0;
  logic                rst_n, downloading, vblank, sdram_ack, data_rdy;
  logic [SLOTS-1:0]    slot_req;
  logic [SLOTS*AW-1:0] slot_addr;

  logic [SLOTS-1:0] f_sel, r_sel;
  logic             f_req, r_req, f_ref, r_ref, f_rdy, r_rdy, f_to, r_to;
  logic [AW-1:0]    f_addr, r_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtframe_romarb #(.SLOTS(SLOTS), .AW(AW), .RR(0), .TOUT(15)) u_fix (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .vblank(vblank),
    .slot_req(slot_req), .slot_addr(slot_addr), .slot_sel(f_sel),
    .sdram_req(f_req), .sdram_ack(sdram_ack), .sdram_addr(f_addr),
    .data_rdy(data_rdy), .refresh_en(f_ref), .ready(f_rdy), .timeout(f_to)
  );

  jtframe_romarb #(.SLOTS(SLOTS), .AW(AW), .RR(1), .TOUT(15)) u_rr (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .vblank(vblank),
    .slot_req(slot_req), .slot_addr(slot_addr), .slot_sel(r_sel),
    .sdram_req(r_req), .sdram_ack(sdram_ack), .sdram_addr(r_addr),
    .data_rdy(data_rdy), .refresh_en(r_ref), .ready(r_rdy), .timeout(r_to)
  );

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(22'h3000 + i * 22'h0101);
  endfunction

  task automatic clear_dl();
    downloading = 1'b1;
    @(negedge clk);
    downloading = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; downloading = 1'b0; vblank = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; slot_req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({f_sel, f_req, f_addr, f_ref, f_rdy, f_to} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%h req=%b addr=%h ref=%b rdy=%b to=%b required all 0",
               f_sel, f_req, f_addr, f_ref, f_rdy, f_to);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (f_rdy !== (k == 4)) begin
        errors++;
        $display("FAIL ready_delay cycle %0d: got %b required %b", k, f_rdy, (k == 4));
      end
      checks++;
      if ({f_sel, f_req, f_ref, f_to} !== '0) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: got sel=%h req=%b ref=%b to=%b required 0",
                 k, f_sel, f_req, f_ref, f_to);
      end
    end
  endtask

  task automatic test_refresh();
    slot_req = '0; vblank = 1'b1;
    @(negedge clk);
    checks++;
    if (f_ref !== 1'b1 || r_ref !== 1'b1) begin
      errors++;
      $display("FAIL refresh_vblank1: got %b/%b required 1/1", f_ref, r_ref);
    end
    vblank = 1'b0;
    @(negedge clk);
    checks++;
    if (f_ref !== 1'b0 || r_ref !== 1'b0) begin
      errors++;
      $display("FAIL refresh_vblank0: got %b/%b required 0/0", f_ref, r_ref);
    end
  endtask

  task automatic test_fixed_back_to_back();
    vblank = 1'b1;
    slot_req = 9'h014;
    @(negedge clk);
    checks++;
    if (f_sel !== 9'h004 || f_req !== 1'b1 || f_addr !== addr_of(2) || f_ref !== 1'b0) begin
      errors++;
      $display("FAIL fixed_grant2: got sel=%h req=%b addr=%h ref=%b required 004 1 %h 0",
               f_sel, f_req, f_addr, f_ref, addr_of(2));
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    checks++;
    if (f_req !== 1'b0 || f_sel !== 9'h004) begin
      errors++;
      $display("FAIL ack_drop: got req=%b sel=%h required 0 004", f_req, f_sel);
    end
    @(negedge clk);
    checks++;
    if (f_sel !== 9'h004 || f_req !== 1'b0) begin
      errors++;
      $display("FAIL sel_hold: got sel=%h req=%b required 004 0", f_sel, f_req);
    end
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    checks++;
    if (f_sel !== 9'h010 || f_req !== 1'b1 || f_addr !== addr_of(4) || f_ref !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back4: got sel=%h req=%b addr=%h ref=%b required 010 1 %h 0",
               f_sel, f_req, f_addr, f_ref, addr_of(4));
    end
    slot_req = '0;
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    checks++;
    if (f_sel !== '0 || f_req !== 1'b0 || f_ref !== 1'b1) begin
      errors++;
      $display("FAIL return_idle: got sel=%h req=%b ref=%b required 000 0 1", f_sel, f_req, f_ref);
    end
    vblank = 1'b0;
    // data_rdy while idle must not disturb anything
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    checks++;
    if (f_sel !== '0 || f_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_rdy_ignored: got sel=%h req=%b required 000 0", f_sel, f_req);
    end
  endtask

  task automatic test_round_robin();
    clear_dl();
    slot_req = 9'h1FF;
    @(negedge clk);
    checks++;
    if (r_sel !== 9'h001 || r_addr !== addr_of(0)) begin
      errors++;
      $display("FAIL rr_first: got sel=%h addr=%h required 001 %h", r_sel, r_addr, addr_of(0));
    end
    data_rdy = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      logic [SLOTS-1:0] exp_sel;
      exp_sel = SLOTS'(1) << (n % 9);
      @(negedge clk);
      checks++;
      if (r_sel !== exp_sel || r_addr !== addr_of(n % 9) || r_req !== 1'b1) begin
        errors++;
        $display("FAIL rr_step%0d: got sel=%h addr=%h req=%b required %h %h 1",
                 n, r_sel, r_addr, r_req, exp_sel, addr_of(n % 9));
      end
    end
    slot_req = '0;
    @(negedge clk);
    data_rdy = 1'b0;
  endtask

  task automatic test_watchdog();
    clear_dl();
    slot_req = 9'h001;
    @(negedge clk);
    slot_req = '0;
    checks++;
    if (f_sel !== 9'h001 || f_req !== 1'b1) begin
      errors++;
      $display("FAIL wd_grant: got sel=%h req=%b required 001 1", f_sel, f_req);
    end
`ifdef JTFRAME_ROMARB_WDOG_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (f_to !== (k == 15) || (k < 15 && f_sel !== 9'h001) || (k >= 15 && f_sel !== '0)) begin
        errors++;
        $display("FAIL wd_cycle%0d: got to=%b sel=%h required to=%b", k, f_to, f_sel, (k == 15));
      end
    end
    checks++;
    if (f_req !== 1'b0) begin
      errors++;
      $display("FAIL wd_req_clear: got %b required 0", f_req);
    end
`else
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (f_sel !== 9'h001 || f_to !== 1'b0) begin
        errors++;
        $display("FAIL no_wd_hold: got sel=%h to=%b required 001 0", f_sel, f_to);
      end
    end
`endif
  endtask

  task automatic test_download_abort();
    clear_dl();
    repeat (5) @(negedge clk);
    slot_req = 9'h020;
    @(negedge clk);
    checks++;
    if (f_sel !== 9'h020 || f_addr !== addr_of(5) || f_rdy !== 1'b1) begin
      errors++;
      $display("FAIL dl_pre: got sel=%h addr=%h rdy=%b required 020 %h 1", f_sel, f_addr, f_rdy, addr_of(5));
    end
    downloading = 1'b1;
    @(negedge clk);
    checks++;
    if ({f_sel, f_req, f_addr, f_ref, f_rdy, f_to} !== '0 || r_sel !== '0) begin
      errors++;
      $display("FAIL dl_clear: got sel=%h req=%b addr=%h ref=%b rdy=%b to=%b rsel=%h required all 0",
               f_sel, f_req, f_addr, f_ref, f_rdy, f_to, r_sel);
    end
    downloading = 1'b0;
    slot_req = '0;
  endtask

  initial begin
    for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = addr_of(i);
    test_reset();
    test_refresh();
    test_fixed_back_to_back();
    test_round_robin();
    test_watchdog();
    test_download_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
